ex_mul_ctrl: RTL and testbench

EX-stage requester for the iterative multiplier `ex_mul`. It accepts decoded RV32M multiply instructions, launches `ex_mul` and holds its start request for the whole operation. It stalls the pipeline until the result returns, then presents a one-cycle register writeback. It also handles flushes, rd=x0 suppression, a last-result cache and a watchdog timeout.

---
 rtl/ex_mul_ctrl_if.sv | 41 ++++
 rtl/ex_mul_ctrl.sv | 176 +++++++++++++++++
 tb/tb_ex_mul_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ex_mul_ctrl_if.sv
// Signal bundle between the EX-stage multiply requester, the pipeline/writeback
// port and the iterative multiplier ex_mul.
interface ex_mul_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              inst_valid_i;
    logic [2:0]        inst_op_i;
    logic [DATA_W-1:0] rs1_data_i;
    logic [DATA_W-1:0] rs2_data_i;
    logic [ADDR_W-1:0] rd_addr_i;
    logic              flush_i;
    logic              stall_o;
    logic              mul_start_o;
    logic [DATA_W-1:0] mul_multiplicand_o;
    logic [DATA_W-1:0] mul_multiplier_o;
    logic [2:0]        mul_op_o;
    logic [ADDR_W-1:0] mul_reg_waddr_o;
    logic              mul_ready_i;
    logic [DATA_W-1:0] mul_res_i;
    logic              mul_busy_i;
    logic [ADDR_W-1:0] mul_reg_waddr_i;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_waddr_o;
    logic [DATA_W-1:0] wb_wdata_o;
    logic              err_o;

    modport master (
        input  inst_valid_i, inst_op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
               mul_ready_i, mul_res_i, mul_busy_i, mul_reg_waddr_i,
        output stall_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
               mul_reg_waddr_o, wb_we_o, wb_waddr_o, wb_wdata_o, err_o
    );

    modport slave (
        output inst_valid_i, inst_op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
               mul_ready_i, mul_res_i, mul_busy_i, mul_reg_waddr_i,
        input  stall_o, mul_start_o, mul_multiplicand_o, mul_multiplier_o, mul_op_o,
               mul_reg_waddr_o, wb_we_o, wb_waddr_o, wb_wdata_o, err_o
    );
endinterface

// File: rtl/ex_mul_ctrl.sv
// EX-stage requester for the iterative multiplier: launches ex_mul, stalls the
// pipeline until the result returns, and issues a one-cycle writeback.
module ex_mul_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int TIMEOUT_CYC = 48
) (
    input  logic          clk,
    input  logic          rst,
    ex_mul_ctrl_if.master bus
);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] rs1_q, rs1_d;
    logic [DATA_W-1:0] rs2_q, rs2_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] wb_wdata_q, wb_wdata_d;
    logic              cache_vld_q, cache_vld_d;
    logic [2:0]        cache_op_q, cache_op_d;
    logic [DATA_W-1:0] cache_rs1_q, cache_rs1_d;
    logic [DATA_W-1:0] cache_rs2_q, cache_rs2_d;
    logic [DATA_W-1:0] cache_res_q, cache_res_d;
    logic              launch_s;
    logic              hit_s;
    logic              stall_s;
    logic              start_s;
    logic              we_s;
    logic              unused_busy_s;

    // Gating with rst keeps the combinational stall low while reset is held.
    assign launch_s = !rst && bus.inst_valid_i && (bus.rd_addr_i != '0) && !bus.flush_i;
    // The cache key is the operand values themselves, so register writes never stale it.
    assign hit_s    = cache_vld_q && (bus.inst_op_i == cache_op_q) &&
                      (bus.rs1_data_i == cache_rs1_q) && (bus.rs2_data_i == cache_rs2_q);
    assign unused_busy_s = bus.mul_busy_i;

    // Next-state, datapath capture and output decode.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        err_d       = 1'b0;
        wb_wdata_d  = wb_wdata_q;
        cache_vld_d = cache_vld_q && !bus.flush_i;
        cache_op_d  = cache_op_q;
        cache_rs1_d = cache_rs1_q;
        cache_rs2_d = cache_rs2_q;
        cache_res_d = cache_res_q;
        stall_s     = 1'b0;
        start_s     = 1'b0;
        we_s        = 1'b0;
        case (state_q)
            IDLE: begin
                if (launch_s) begin
                    stall_s = 1'b1;
                    op_d    = bus.inst_op_i;
                    rs1_d   = bus.rs1_data_i;
                    rs2_d   = bus.rs2_data_i;
                    rd_d    = bus.rd_addr_i;
                    cnt_d   = '0;
                    tmo_d   = 1'b0;
                    if (hit_s) begin
                        wb_wdata_d = cache_res_q;
                        state_d    = DONE;
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                stall_s = 1'b1;
                start_s = 1'b1;
                cnt_d   = cnt_q + CNT_W'(1);
                if (bus.flush_i) begin
                    state_d = DRAIN;
                end else if (bus.mul_ready_i) begin
                    wb_wdata_d = bus.mul_res_i;
                    err_d      = (bus.mul_reg_waddr_i != rd_q);
                    state_d    = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    wb_wdata_d = '0;
                    err_d      = 1'b1;
                    tmo_d      = 1'b1;
                    state_d    = DONE;
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.flush_i) begin
                    we_s        = 1'b0;
                    cache_vld_d = 1'b0;
                end else begin
                    we_s        = 1'b1;
                    cache_vld_d = !tmo_q;
                    cache_op_d  = op_q;
                    cache_rs1_d = rs1_q;
                    cache_rs2_d = rs2_q;
                    cache_res_d = wb_wdata_q;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything including the cache.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            op_q        <= 3'd0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            err_q       <= 1'b0;
            wb_wdata_q  <= '0;
            cache_vld_q <= 1'b0;
            cache_op_q  <= 3'd0;
            cache_rs1_q <= '0;
            cache_rs2_q <= '0;
            cache_res_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
            wb_wdata_q  <= wb_wdata_d;
            cache_vld_q <= cache_vld_d;
            cache_op_q  <= cache_op_d;
            cache_rs1_q <= cache_rs1_d;
            cache_rs2_q <= cache_rs2_d;
            cache_res_q <= cache_res_d;
        end
    end

    assign bus.stall_o            = stall_s;
    assign bus.mul_start_o        = start_s;
    assign bus.mul_multiplicand_o = rs1_q;
    assign bus.mul_multiplier_o   = rs2_q;
    assign bus.mul_op_o           = op_q;
    assign bus.mul_reg_waddr_o    = rd_q;
    assign bus.wb_we_o            = we_s;
    assign bus.wb_waddr_o         = rd_q;
    assign bus.wb_wdata_o         = wb_wdata_q;
    assign bus.err_o              = err_q;
endmodule

// File: tb/tb_ex_mul_ctrl.sv
// Directed bench for ex_mul_ctrl with a stub ex_mul of fixed latency that can be
// told to hang or to return a wrong rd.
module tb_ex_mul_ctrl;
    localparam logic [2:0] OP_MUL   = 3'b000;
    localparam logic [2:0] OP_MULH  = 3'b001;
    localparam logic [2:0] OP_MULHU = 3'b011;
    localparam int         STUB_LAT = 8;

    logic clk;
    logic rst;
    logic stub_hang;
    logic stub_bad_rd;
    logic [7:0] stub_cnt;
    int n_checks;
    int n_fail;

    int obs_stall, obs_start, obs_rises, obs_we, obs_err, obs_we_idx;
    logic obs_done;
    logic [4:0]  obs_addr;
    logic [31:0] obs_data, obs_mc, obs_mp;

    ex_mul_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    ex_mul_ctrl #(.DATA_W(32), .ADDR_W(5), .TIMEOUT_CYC(48)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [31:0] mul_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] xa, xb, p;
        xa = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
        xb = (op == 3'b001) ? {{32{b[31]}}, b} : {32'd0, b};
        p  = xa * xb;
        return (op == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // Stub multiplier: counts cycles while start is held, result after STUB_LAT.
    always @(posedge clk or posedge rst) begin
        if (rst) stub_cnt <= 8'd0;
        else if (bus.mul_start_o) stub_cnt <= stub_cnt + 8'd1;
        else stub_cnt <= 8'd0;
    end

    assign bus.mul_ready_i     = bus.mul_start_o && !stub_hang && (stub_cnt == 8'(STUB_LAT));
    assign bus.mul_busy_i      = bus.mul_start_o;
    assign bus.mul_res_i       = mul_model(bus.mul_op_o, bus.mul_multiplicand_o, bus.mul_multiplier_o);
    assign bus.mul_reg_waddr_i = stub_bad_rd ? (bus.mul_reg_waddr_o ^ 5'h01) : bus.mul_reg_waddr_o;

    // Presents one instruction and holds it until the pipeline advances (stall low).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int max_cyc);
        logic prev_start;
        obs_stall = 0; obs_start = 0; obs_rises = 0; obs_we = 0; obs_err = 0;
        obs_we_idx = -1; obs_done = 1'b0; prev_start = 1'b0;
        obs_addr = 5'd0; obs_data = 32'd0; obs_mc = 32'd0; obs_mp = 32'd0;
        bus.inst_valid_i = 1'b1; bus.inst_op_i = op;
        bus.rs1_data_i = a; bus.rs2_data_i = b; bus.rd_addr_i = rd;
        for (int i = 0; i < max_cyc && !obs_done; i++) begin
            @(negedge clk);
            if (bus.stall_o) obs_stall++;
            if (bus.mul_start_o) begin
                if (!prev_start) begin
                    obs_rises++;
                    obs_mc = bus.mul_multiplicand_o;
                    obs_mp = bus.mul_multiplier_o;
                end
                obs_start++;
            end
            prev_start = bus.mul_start_o;
            if (bus.err_o) obs_err++;
            if (bus.wb_we_o) begin
                obs_we++; obs_we_idx = i; obs_addr = bus.wb_waddr_o; obs_data = bus.wb_wdata_o;
            end
            if (!bus.stall_o) obs_done = 1'b1;
            @(posedge clk); #1;
        end
        bus.inst_valid_i = 1'b0;
    endtask

    task automatic watch_idle(input int n);
        obs_we = 0; obs_start = 0; obs_stall = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.wb_we_o) obs_we++;
            if (bus.mul_start_o) obs_start++;
            if (bus.stall_o) obs_stall++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bus.inst_valid_i = 1'b1; bus.rd_addr_i = 5'd5; bus.inst_op_i = OP_MUL;
        #2;
        n_checks++; if (bus.stall_o !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%b exp=0", bus.stall_o); end
        n_checks++; if (bus.mul_start_o !== 1'b0) begin n_fail++; $display("FAIL rst_start got=%b exp=0", bus.mul_start_o); end
        n_checks++; if ({bus.wb_we_o, bus.err_o} !== 2'b00) begin n_fail++; $display("FAIL rst_we_err got=%b exp=00", {bus.wb_we_o, bus.err_o}); end
        n_checks++; if ({bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.wb_wdata_o} !== 96'd0) begin
            n_fail++; $display("FAIL rst_data got=%h/%h/%h exp=0", bus.mul_multiplicand_o, bus.mul_multiplier_o, bus.wb_wdata_o); end
        n_checks++; if ({bus.wb_waddr_o, bus.mul_reg_waddr_o, bus.mul_op_o} !== 13'd0) begin
            n_fail++; $display("FAIL rst_addr got=%h/%h/%h exp=0", bus.wb_waddr_o, bus.mul_reg_waddr_o, bus.mul_op_o); end
        bus.inst_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_mul_basic();
        run_op(OP_MUL, 32'd7, 32'd6, 5'd5, 40);
        n_checks++; if (obs_we !== 1) begin n_fail++; $display("FAIL basic_we_cnt got=%0d exp=1", obs_we); end
        n_checks++; if (obs_addr !== 5'd5) begin n_fail++; $display("FAIL basic_waddr got=%0d exp=5", obs_addr); end
        n_checks++; if (obs_data !== 32'h0000002A) begin n_fail++; $display("FAIL basic_wdata got=%h exp=0000002a", obs_data); end
        n_checks++; if (obs_start !== STUB_LAT + 1) begin n_fail++; $display("FAIL basic_start_cyc got=%0d exp=%0d", obs_start, STUB_LAT + 1); end
        n_checks++; if (obs_rises !== 1) begin n_fail++; $display("FAIL basic_start_cont got=%0d exp=1", obs_rises); end
        n_checks++; if (obs_stall !== STUB_LAT + 2) begin n_fail++; $display("FAIL basic_stall got=%0d exp=%0d", obs_stall, STUB_LAT + 2); end
        n_checks++; if (obs_we_idx !== STUB_LAT + 2) begin n_fail++; $display("FAIL basic_latency got=%0d exp=%0d", obs_we_idx, STUB_LAT + 2); end
        n_checks++; if ({obs_mc, obs_mp} !== {32'd7, 32'd6}) begin n_fail++; $display("FAIL basic_operands got=%h/%h exp=7/6", obs_mc, obs_mp); end
        n_checks++; if (obs_err !== 0) begin n_fail++; $display("FAIL basic_err got=%0d exp=0", obs_err); end
    endtask

    task automatic test_mulh();
        run_op(OP_MULH, 32'hFFFFFFFE, 32'd3, 5'd10, 40);
        n_checks++; if (obs_data !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mulh_wdata got=%h exp=ffffffff", obs_data); end
        n_checks++; if (obs_we !== 1) begin n_fail++; $display("FAIL mulh_we_cnt got=%0d exp=1", obs_we); end
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd11, 40);
        n_checks++; if (obs_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL mulhu_wdata got=%h exp=fffffffe", obs_data); end
        n_checks++; if (obs_addr !== 5'd11) begin n_fail++; $display("FAIL mulhu_waddr got=%0d exp=11", obs_addr); end
    endtask

    task automatic test_back_to_back();
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 40);
        n_checks++; if (obs_start !== 0) begin n_fail++; $display("FAIL hit_start got=%0d exp=0", obs_start); end
        n_checks++; if (obs_stall !== 1) begin n_fail++; $display("FAIL hit_stall got=%0d exp=1", obs_stall); end
        n_checks++; if (obs_data !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL hit_wdata got=%h exp=fffffffe", obs_data); end
        n_checks++; if ({obs_we, obs_we_idx} !== {32'd1, 32'd1}) begin n_fail++; $display("FAIL hit_wb got=%0d@%0d exp=1@1", obs_we, obs_we_idx); end
        n_checks++; if (obs_addr !== 5'd12) begin n_fail++; $display("FAIL hit_waddr got=%0d exp=12", obs_addr); end
    endtask

    task automatic test_flush();
        int we_seen;
        we_seen = 0;
        bus.inst_valid_i = 1'b1; bus.inst_op_i = OP_MUL;
        bus.rs1_data_i = 32'd3; bus.rs2_data_i = 32'd5; bus.rd_addr_i = 5'd7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); if (bus.wb_we_o) we_seen++;
            @(posedge clk); #1;
        end
        bus.flush_i = 1'b1; bus.inst_valid_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.mul_start_o !== 1'b1) begin n_fail++; $display("FAIL flush_start_held got=%b exp=1", bus.mul_start_o); end
        if (bus.wb_we_o) we_seen++;
        @(posedge clk); #1;
        bus.flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if ({bus.mul_start_o, bus.stall_o} !== 2'b00) begin n_fail++; $display("FAIL drain_start_stall got=%b exp=00", {bus.mul_start_o, bus.stall_o}); end
        if (bus.wb_we_o) we_seen++;
        n_checks++; if (we_seen !== 0) begin n_fail++; $display("FAIL flush_no_wb got=%0d exp=0", we_seen); end
        @(posedge clk); #1;
        run_op(OP_MUL, 32'd2, 32'd3, 5'd6, 40);
        n_checks++; if (obs_data !== 32'd6) begin n_fail++; $display("FAIL after_flush_wdata got=%h exp=6", obs_data); end
        n_checks++; if (obs_we_idx !== STUB_LAT + 2) begin n_fail++; $display("FAIL after_flush_latency got=%0d exp=%0d", obs_we_idx, STUB_LAT + 2); end
    endtask

    task automatic test_flush_idle();
        bus.inst_valid_i = 1'b1; bus.inst_op_i = OP_MUL;
        bus.rs1_data_i = 32'd2; bus.rs2_data_i = 32'd3; bus.rd_addr_i = 5'd6; bus.flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if ({bus.stall_o, bus.mul_start_o} !== 2'b00) begin n_fail++; $display("FAIL flush_idle got=%b exp=00", {bus.stall_o, bus.mul_start_o}); end
        @(posedge clk); #1;
        bus.flush_i = 1'b0; bus.inst_valid_i = 1'b0;
        run_op(OP_MUL, 32'd2, 32'd3, 5'd6, 40);
        n_checks++; if (obs_start !== STUB_LAT + 1) begin n_fail++; $display("FAIL flush_inval_cache got=%0d exp=%0d", obs_start, STUB_LAT + 1); end
    endtask

    task automatic test_rd_zero();
        run_op(OP_MUL, 32'd9, 32'd9, 5'd0, 10);
        n_checks++; if ({obs_stall, obs_start, obs_we} !== 96'd0) begin n_fail++; $display("FAIL rd0_launch got=%0d/%0d/%0d exp=0/0/0", obs_stall, obs_start, obs_we); end
        watch_idle(3);
        n_checks++; if ({obs_start, obs_we} !== 64'd0) begin n_fail++; $display("FAIL rd0_after got=%0d/%0d exp=0/0", obs_start, obs_we); end
    endtask

    task automatic test_timeout();
        stub_hang = 1'b1;
        run_op(OP_MUL, 32'd4, 32'd4, 5'd3, 80);
        stub_hang = 1'b0;
        n_checks++; if (obs_start !== 48) begin n_fail++; $display("FAIL tmo_req_cyc got=%0d exp=48", obs_start); end
        n_checks++; if (obs_err !== 1) begin n_fail++; $display("FAIL tmo_err got=%0d exp=1", obs_err); end
        n_checks++; if ({obs_we, obs_we_idx} !== {32'd1, 32'd49}) begin n_fail++; $display("FAIL tmo_wb got=%0d@%0d exp=1@49", obs_we, obs_we_idx); end
        n_checks++; if ({obs_addr, obs_data} !== {5'd3, 32'd0}) begin n_fail++; $display("FAIL tmo_wdata got=%0d/%h exp=3/0", obs_addr, obs_data); end
        run_op(OP_MUL, 32'd4, 32'd4, 5'd3, 40);
        n_checks++; if (obs_start !== STUB_LAT + 1) begin n_fail++; $display("FAIL tmo_cache_inval got=%0d exp=%0d", obs_start, STUB_LAT + 1); end
        n_checks++; if (obs_data !== 32'd16) begin n_fail++; $display("FAIL tmo_retry_wdata got=%h exp=10", obs_data); end
    endtask

    task automatic test_mismatch();
        stub_bad_rd = 1'b1;
        run_op(OP_MUL, 32'd5, 32'd5, 5'd9, 40);
        stub_bad_rd = 1'b0;
        n_checks++; if (obs_err !== 1) begin n_fail++; $display("FAIL mismatch_err got=%0d exp=1", obs_err); end
        n_checks++; if ({obs_addr, obs_data} !== {5'd9, 32'd25}) begin n_fail++; $display("FAIL mismatch_wb got=%0d/%h exp=9/19", obs_addr, obs_data); end
    endtask

    task automatic test_reset_mid();
        bus.inst_valid_i = 1'b1; bus.inst_op_i = OP_MUL;
        bus.rs1_data_i = 32'd11; bus.rs2_data_i = 32'd13; bus.rd_addr_i = 5'd4;
        repeat (4) @(posedge clk);
        #2;
        n_checks++; if (bus.mul_start_o !== 1'b1) begin n_fail++; $display("FAIL rmid_pre_start got=%b exp=1", bus.mul_start_o); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if ({bus.mul_start_o, bus.stall_o, bus.wb_we_o, bus.err_o} !== 4'b0000) begin
            n_fail++; $display("FAIL rmid_ctrl got=%b exp=0000", {bus.mul_start_o, bus.stall_o, bus.wb_we_o, bus.err_o}); end
        n_checks++; if ({bus.mul_multiplicand_o, bus.mul_reg_waddr_o} !== 37'd0) begin
            n_fail++; $display("FAIL rmid_regs got=%h/%h exp=0", bus.mul_multiplicand_o, bus.mul_reg_waddr_o); end
        bus.inst_valid_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        watch_idle(4);
        n_checks++; if ({obs_we, obs_start} !== 64'd0) begin n_fail++; $display("FAIL rmid_no_wb got=%0d/%0d exp=0/0", obs_we, obs_start); end
        run_op(OP_MUL, 32'h0000FFFF, 32'h00010000, 5'd8, 40);
        n_checks++; if (obs_data !== 32'hFFFF0000) begin n_fail++; $display("FAIL rmid_next_wdata got=%h exp=ffff0000", obs_data); end
        n_checks++; if (obs_we !== 1) begin n_fail++; $display("FAIL rmid_next_we got=%0d exp=1", obs_we); end
    endtask

    initial begin
        clk = 1'b0; rst = 1'b1; stub_hang = 1'b0; stub_bad_rd = 1'b0;
        n_checks = 0; n_fail = 0;
        bus.inst_valid_i = 1'b0; bus.inst_op_i = 3'd0; bus.rs1_data_i = 32'd0;
        bus.rs2_data_i = 32'd0; bus.rd_addr_i = 5'd0; bus.flush_i = 1'b0;
        test_reset();
        test_mul_basic();
        test_mulh();
        test_back_to_back();
        test_flush();
        test_flush_idle();
        test_rd_zero();
        test_timeout();
        test_mismatch();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
